// File: rtl/instr_decode_pkg.sv
// Decode-stage types shared with the uop queue: the decoded uop record and the queue depth.
package instr_decode;

  localparam int IQ_DEPTH = 8;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [15:0] simid;
    logic [7:0]  opcode;
  } t_uinstr;

endpackage

// File: rtl/uinstr_queue.sv
// Micro-op queue between decode DE1 and rename: circular buffer with registered
// back-pressure, flush and one cycle of push-to-head latency.
module uinstr_queue
  import instr_decode::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  t_uinstr                      uinstr_de1,
  output logic                         stall_de,
  input  logic                         flush,
  input  logic                         deq,
  output t_uinstr                      uinstr_iq,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("uinstr_queue: DEPTH must be a power of two and at least 2");
  end

  t_uinstr         mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            push;
  logic            pop;
  logic            empty;

  // Full/empty come from the count alone; stall is a pure function of registered state.
  assign empty    = (occupancy == '0);
  assign stall_de = (occupancy == FULL_CNT);
  assign push     = uinstr_de1.valid & ~stall_de & ~flush;
  assign pop      = deq & ~empty & ~flush;

  // Storage is data only: never reset, never cleared by flush.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= uinstr_de1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occupancy <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else if (flush) begin
      occupancy <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Head is read straight from storage; the empty case is forced to zero.
  always_comb begin
    uinstr_iq = '0;
    if (!empty) begin
      uinstr_iq       = mem[rd_ptr];
      uinstr_iq.valid = 1'b1;
    end
  end

`ifdef SIMULATION
  always @(posedge clk) begin
    if (reset) begin
      if (push) $display("INFO uinstr_queue push simid=%0d pc=%h", uinstr_de1.simid, uinstr_de1.pc);
      if (pop)  $display("INFO uinstr_queue pop  simid=%0d pc=%h", uinstr_iq.simid, uinstr_iq.pc);
    end
  end
`endif

`ifdef ASSERT
  always @(posedge clk) begin
    if (reset) begin
      a_no_deq_empty: assert (!(deq && empty))
        else $warning("uinstr_queue: deq while empty");
      a_occ_bound: assert (occupancy <= FULL_CNT)
        else $error("uinstr_queue: occupancy %0d exceeds DEPTH", occupancy);
    end
  end

  a_head_stable: assert property (@(posedge clk) disable iff (!reset)
    (uinstr_iq.valid && !deq && !flush) |=> $stable(uinstr_iq))
    else $error("uinstr_queue: head changed while held");
`endif

endmodule

// File: tb/tb_uinstr_queue.sv
// Bench for uinstr_queue: directed scenarios plus randomized traffic checked against a queue model.
module tb_uinstr_queue;
  import instr_decode::*;

  localparam int DEPTH = IQ_DEPTH;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          reset;
  t_uinstr       uinstr_de1;
  logic          stall_de;
  logic          flush;
  logic          deq;
  t_uinstr       uinstr_iq;
  logic [CW-1:0] occupancy;

  uinstr_queue #(.DEPTH(IQ_DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .uinstr_de1 (uinstr_de1),
    .stall_de   (stall_de),
    .flush      (flush),
    .deq        (deq),
    .uinstr_iq  (uinstr_iq),
    .occupancy  (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           checks    = 0;
  int           failures  = 0;
  int           simid_ctr = 1;
  logic         last_push;
  t_uinstr      model_q [$];
  logic [31:0]  popped_pcs [$];

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic t_uinstr mk(input logic [31:0] pc);
    t_uinstr u;
    u.valid  = 1'b1;
    u.pc     = pc;
    u.simid  = simid_ctr[15:0];
    u.opcode = 8'($urandom);
    simid_ctr++;
    return u;
  endfunction

  function automatic t_uinstr exp_head();
    return (model_q.size() != 0) ? model_q[0] : t_uinstr'('0);
  endfunction

  // One clock: drive at the falling edge, check, advance the model at the rising edge, check again.
  task automatic cycle(input t_uinstr din, input logic d, input logic f);
    logic    p_push;
    logic    p_pop;
    t_uinstr h;
    @(negedge clk);
    uinstr_de1 = din;
    deq        = d;
    flush      = f;
    #1;
    check("stall_pre", stall_de, model_q.size() == DEPTH);
    check("head_pre", uinstr_iq, exp_head());
    p_push = din.valid && (model_q.size() != DEPTH) && !f;
    p_pop  = d && (model_q.size() != 0) && !f;
    @(posedge clk);
    if (f) begin
      model_q.delete();
    end else begin
      if (p_pop) begin
        h = model_q.pop_front();
        popped_pcs.push_back(h.pc);
      end
      if (p_push) model_q.push_back(din);
    end
    #1;
    check("occupancy", occupancy, model_q.size());
    check("head_post", uinstr_iq, exp_head());
    check("stall_post", stall_de, model_q.size() == DEPTH);
    last_push = p_push;
  endtask

  task automatic idle_cycle(input logic d);
    cycle(t_uinstr'('0), d, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (model_q.size() != 0) idle_cycle(1'b1);
    end
    check("drained", occupancy, 0);
  endtask

  initial begin
    t_uinstr u9;
    t_uinstr u;
    t_uinstr ur;
    int      idx;
    int      guard;
    logic    v;

    reset      = 1'b0;
    uinstr_de1 = '0;
    flush      = 1'b0;
    deq        = 1'b0;
    last_push  = 1'b0;
    #2;
    check("rst_occupancy", occupancy, 0);
    check("rst_stall", stall_de, 0);
    check("rst_head", uinstr_iq, 0);
    @(negedge clk);
    reset = 1'b1;

    // Fill to full with back-to-back pushes, then a held ninth uop.
    for (int i = 0; i < DEPTH; i++) begin
      cycle(mk(32'h1000 + 32'(i * 4)), 1'b0, 1'b0);
      check("fill_occ", occupancy, i + 1);
    end
    check("full_stall", stall_de, 1);
    u9 = mk(32'h1000 + 32'(DEPTH * 4));
    cycle(u9, 1'b0, 1'b0);
    cycle(u9, 1'b0, 1'b0);
    check("held_occ", occupancy, DEPTH);
    cycle(u9, 1'b1, 1'b0);
    check("pop_full_occ", occupancy, DEPTH - 1);
    check("pop_full_stall", stall_de, 0);
    cycle(u9, 1'b0, 1'b0);
    check("held_pushed_occ", occupancy, DEPTH);
    popped_pcs.delete();
    drain();
    check("fill_pop_count", popped_pcs.size(), DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      if (i < popped_pcs.size())
        check("fill_order", popped_pcs[i], 32'h1004 + 32'(i * 4));
    end

    // Push and deq together on an empty queue.
    cycle(mk(32'h2000), 1'b1, 1'b0);
    check("empty_pushdeq_occ", occupancy, 1);
    check("empty_pushdeq_pc", uinstr_iq.pc, 32'h2000);
    check("empty_pushdeq_vld", uinstr_iq.valid, 1);
    drain();

    // Twenty uops with random decode/deq activity; order must survive pointer wraps.
    popped_pcs.delete();
    idx   = 0;
    guard = 0;
    while ((idx < 20 || model_q.size() != 0) && guard < 1000) begin
      v = (idx < 20) && ($urandom_range(0, 3) != 0);
      u = '0;
      if (v) u = mk(32'(idx * 4));
      cycle(u, 1'($urandom_range(0, 1)), 1'b0);
      if (last_push) idx++;
      guard++;
    end
    check("random_done", guard < 1000, 1);
    check("random_count", popped_pcs.size(), 20);
    for (int i = 0; i < 20; i++) begin
      if (i < popped_pcs.size()) check("random_order", popped_pcs[i], 32'(i * 4));
    end

    // Flush beats a simultaneous push and pop.
    for (int i = 0; i < 5; i++) cycle(mk(32'h3000 + 32'(i * 4)), 1'b0, 1'b0);
    check("pre_flush_occ", occupancy, 5);
    cycle(mk(32'h3100), 1'b1, 1'b1);
    check("flush_occ", occupancy, 0);
    check("flush_vld", uinstr_iq.valid, 0);
    check("flush_stall", stall_de, 0);
    idle_cycle(1'b0);
    check("flush_dropped", occupancy, 0);
    cycle(mk(32'h3200), 1'b0, 1'b0);
    check("post_flush_pc", uinstr_iq.pc, 32'h3200);
    drain();

    // Asynchronous reset mid-stream at occupancy three.
    for (int i = 0; i < 3; i++) cycle(mk(32'h4000 + 32'(i * 4)), 1'b0, 1'b0);
    check("pre_reset_occ", occupancy, 3);
    @(negedge clk);
    #2;
    uinstr_de1 = mk(32'h4100);
    deq        = 1'b1;
    reset      = 1'b0;
    #1;
    model_q.delete();
    check("async_rst_occ", occupancy, 0);
    check("async_rst_head", uinstr_iq, 0);
    check("async_rst_stall", stall_de, 0);
    @(posedge clk);
    #1;
    check("rst_hold_occ", occupancy, 0);
    @(negedge clk);
    reset      = 1'b1;
    uinstr_de1 = '0;
    deq        = 1'b0;
    ur = mk(32'h5000);
    cycle(ur, 1'b0, 1'b0);
    check("after_rst_occ", occupancy, 1);
    check("after_rst_head", uinstr_iq, ur);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
